w16_packer: RTL

W16_PACKER -- requirements
Module: w16_packer

---
 rtl/pipe_pkg.sv | 27 ++
 rtl/w16_packer.sv | 94 +++++++++
 2 files changed

// File: rtl/pipe_pkg.sv
// Shared widths, FSM state type and lane-ordering helper for the halfword packer.
package pipe_pkg;

    localparam int HW_W   = 16;
    localparam int WORD_W = 32;

    typedef enum logic {
        EMPTY = 1'b0,
        HALF  = 1'b1
    } pack_state_e;

    // Place the first-arriving halfword in the low or high lane.
    function automatic logic [WORD_W-1:0] pack_word(
        input logic [HW_W-1:0] first,
        input logic [HW_W-1:0] second,
        input logic            low_first
    );
        logic [WORD_W-1:0] word_v;
        if (low_first) begin
            word_v = {second, first};
        end else begin
            word_v = {first, second};
        end
        return word_v;
    endfunction

endpackage

// File: rtl/w16_packer.sv
// Packs a stream of 16-bit halfwords into 32-bit words; flush pushes out a held
// halfword as a zero-padded partial word.
module w16_packer
    import pipe_pkg::*;
#(
    parameter int LOW_FIRST = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [HW_W-1:0]   in_data,
    input  logic              in_en,
    input  logic              flush,
    output logic [WORD_W-1:0] out_data,
    output logic              out_en,
    output logic              out_partial,
    output logic              pending,
    output logic [HW_W-1:0]   word_cnt
);

    localparam logic LOW_FIRST_B = (LOW_FIRST != 0) ? 1'b1 : 1'b0;

    pack_state_e       state_r;
    pack_state_e       state_nxt_s;
    logic [HW_W-1:0]   hold_r;
    logic [HW_W-1:0]   hold_nxt_s;
    logic              emit_s;
    logic              emit_partial_s;
    logic [WORD_W-1:0] emit_data_s;

    // Next-state, hold update and word to emit for the current inputs.
    always_comb begin
        state_nxt_s    = state_r;
        hold_nxt_s     = hold_r;
        emit_s         = 1'b0;
        emit_partial_s = 1'b0;
        emit_data_s    = out_data;
        case (state_r)
            EMPTY: begin
                if (in_en && flush) begin
                    emit_s         = 1'b1;
                    emit_partial_s = 1'b1;
                    emit_data_s    = pack_word(in_data, 16'h0000, LOW_FIRST_B);
                end else if (in_en) begin
                    hold_nxt_s  = in_data;
                    state_nxt_s = HALF;
                end else begin
                    state_nxt_s = EMPTY;
                end
            end
            HALF: begin
                // A completing halfword absorbs a coincident flush.
                if (in_en) begin
                    emit_s      = 1'b1;
                    emit_data_s = pack_word(hold_r, in_data, LOW_FIRST_B);
                    state_nxt_s = EMPTY;
                end else if (flush) begin
                    emit_s         = 1'b1;
                    emit_partial_s = 1'b1;
                    emit_data_s    = pack_word(hold_r, 16'h0000, LOW_FIRST_B);
                    state_nxt_s    = EMPTY;
                end else begin
                    state_nxt_s = HALF;
                end
            end
            default: begin
                state_nxt_s = EMPTY;
            end
        endcase
    end

    // State, hold register and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= EMPTY;
            hold_r      <= 16'h0000;
            out_data    <= 32'h0000_0000;
            out_en      <= 1'b0;
            out_partial <= 1'b0;
            word_cnt    <= 16'h0000;
        end else begin
            state_r     <= state_nxt_s;
            hold_r      <= hold_nxt_s;
            out_en      <= emit_s;
            out_partial <= emit_partial_s;
            if (emit_s) begin
                out_data <= emit_data_s;
                word_cnt <= word_cnt + 16'h0001;
            end
        end
    end

    assign pending = (state_r == HALF);

endmodule
